// File: rtl/axis_img_source.sv
// rtl/axis_img_source.sv - AXI-Stream test image generator (h-ramp, v-ramp, checker, constant)
module axis_img_source #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int HBLANK     = 16,
    parameter int VBLANK     = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    localparam int CW = 16;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] X_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST  = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] HB_LAST = CW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [CW-1:0] VB_LAST = CW'((VBLANK > 0) ? VBLANK - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_LINE, S_HBLANK, S_VBLANK} state_t;

    state_t                state_q, state_nx;
    logic [CW-1:0]         x_q, x_nx, y_q, y_nx, cnt_q, cnt_nx;
    logic [1:0]            pat_q, pat_nx;
    logic [DATA_WIDTH-1:0] fill_q, fill_nx;
    logic                  tvalid_nx, tlast_nx, tuser_nx, done_nx;
    logic [DATA_WIDTH-1:0] tdata_nx;
    logic [15:0]           fcnt_nx;
    logic                  load, start;

    function automatic logic [DATA_WIDTH-1:0] pixel(input logic [1:0] sel,
                                                     input logic [CW-1:0] px,
                                                     input logic [CW-1:0] py,
                                                     input logic [DATA_WIDTH-1:0] fill);
        case (sel)
            2'd0:    pixel = DATA_WIDTH'(px);
            2'd1:    pixel = DATA_WIDTH'(py);
            2'd2:    pixel = {DATA_WIDTH{px[3] ^ py[3]}};
            default: pixel = fill;
        endcase
    endfunction

    always_comb begin
        state_nx  = state_q;
        x_nx      = x_q;
        y_nx      = y_q;
        cnt_nx    = cnt_q;
        pat_nx    = pat_q;
        fill_nx   = fill_q;
        tvalid_nx = m_axis_tvalid;
        fcnt_nx   = frame_cnt;
        done_nx   = 1'b0;
        load      = 1'b0;
        start     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) start = 1'b1;
            end
            S_LINE: begin
                if (m_axis_tready) begin
                    if (x_q == X_LAST) begin
                        x_nx = '0;
                        if (y_q == Y_LAST) begin
                            done_nx = 1'b1;
                            fcnt_nx = frame_cnt + 16'd1;
                            y_nx    = '0;
                            if (VBLANK == 0) begin
                                if (enable) begin
                                    start = 1'b1;
                                end else begin
                                    state_nx  = S_IDLE;
                                    tvalid_nx = 1'b0;
                                end
                            end else begin
                                state_nx  = S_VBLANK;
                                cnt_nx    = '0;
                                tvalid_nx = 1'b0;
                            end
                        end else begin
                            y_nx = y_q + ONE;
                            if (HBLANK == 0) begin
                                load = 1'b1;
                            end else begin
                                state_nx  = S_HBLANK;
                                cnt_nx    = '0;
                                tvalid_nx = 1'b0;
                            end
                        end
                    end else begin
                        x_nx = x_q + ONE;
                        load = 1'b1;
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_nx  = S_LINE;
                    tvalid_nx = 1'b1;
                    load      = 1'b1;
                end else begin
                    cnt_nx = cnt_q + ONE;
                end
            end
            default: begin
                if (cnt_q == VB_LAST) begin
                    if (enable) start = 1'b1;
                    else        state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt_q + ONE;
                end
            end
        endcase

        // Frame start re-latches the pattern controls so mid-frame changes wait for the next frame
        if (start) begin
            state_nx  = S_LINE;
            x_nx      = '0;
            y_nx      = '0;
            pat_nx    = pattern_sel;
            fill_nx   = fill_value;
            tvalid_nx = 1'b1;
            load      = 1'b1;
        end

        tdata_nx = m_axis_tdata;
        tlast_nx = m_axis_tlast;
        tuser_nx = m_axis_tuser;
        if (load) begin
            tdata_nx = pixel(pat_nx, x_nx, y_nx, fill_nx);
            tlast_nx = (x_nx == X_LAST);
            tuser_nx = (x_nx == '0) && (y_nx == '0);
        end else if (!tvalid_nx) begin
            tlast_nx = 1'b0;
            tuser_nx = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            pat_q         <= '0;
            fill_q        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            state_q       <= state_nx;
            x_q           <= x_nx;
            y_q           <= y_nx;
            cnt_q         <= cnt_nx;
            pat_q         <= pat_nx;
            fill_q        <= fill_nx;
            m_axis_tvalid <= tvalid_nx;
            m_axis_tdata  <= tdata_nx;
            m_axis_tlast  <= tlast_nx;
            m_axis_tuser  <= tuser_nx;
            frame_done    <= done_nx;
            frame_cnt     <= fcnt_nx;
        end
    end

endmodule

// File: tb/tb_axis_img_source.sv
// tb/tb_axis_img_source.sv - directed bench for axis_img_source
module tb_axis_img_source;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // u_a: 4x2 HB2 VB3
    logic       a_en = 0, a_rdy = 0, a_tvalid, a_tlast, a_tuser, a_done;
    logic [1:0] a_ps = 0;
    logic [7:0] a_fill = 8'hAA, a_tdata;
    logic [15:0] a_fcnt;
    // u_b: 4x2 HB0 VB0
    logic       b_en = 0, b_rdy = 0, b_tvalid, b_tlast, b_tuser, b_done;
    logic [1:0] b_ps = 0;
    logic [7:0] b_fill = 8'h00, b_tdata;
    logic [15:0] b_fcnt;
    // u_c: 16x16 checker
    logic       c_en = 0, c_rdy = 0, c_tvalid, c_tlast, c_tuser, c_done;
    logic [1:0] c_ps = 2;
    logic [7:0] c_fill = 8'h55, c_tdata;
    logic [15:0] c_fcnt;
    // u_d: 1x1 HB0 VB0 for frame counter wrap
    logic       d_en = 0, d_rdy = 0, d_tvalid, d_tlast, d_tuser, d_done;
    logic [1:0] d_ps = 0;
    logic [7:0] d_fill = 8'h00, d_tdata;
    logic [15:0] d_fcnt;

    axis_img_source #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2), .HBLANK(2), .VBLANK(3)) u_a (
        .aclk(aclk), .aresetn(aresetn), .enable(a_en), .pattern_sel(a_ps), .fill_value(a_fill),
        .m_axis_tvalid(a_tvalid), .m_axis_tready(a_rdy), .m_axis_tdata(a_tdata),
        .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .frame_done(a_done), .frame_cnt(a_fcnt));
    axis_img_source #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(2), .HBLANK(0), .VBLANK(0)) u_b (
        .aclk(aclk), .aresetn(aresetn), .enable(b_en), .pattern_sel(b_ps), .fill_value(b_fill),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(b_rdy), .m_axis_tdata(b_tdata),
        .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .frame_done(b_done), .frame_cnt(b_fcnt));
    axis_img_source #(.DATA_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(16), .HBLANK(2), .VBLANK(3)) u_c (
        .aclk(aclk), .aresetn(aresetn), .enable(c_en), .pattern_sel(c_ps), .fill_value(c_fill),
        .m_axis_tvalid(c_tvalid), .m_axis_tready(c_rdy), .m_axis_tdata(c_tdata),
        .m_axis_tlast(c_tlast), .m_axis_tuser(c_tuser), .frame_done(c_done), .frame_cnt(c_fcnt));
    axis_img_source #(.DATA_WIDTH(8), .IMG_WIDTH(1), .IMG_HEIGHT(1), .HBLANK(0), .VBLANK(0)) u_d (
        .aclk(aclk), .aresetn(aresetn), .enable(d_en), .pattern_sel(d_ps), .fill_value(d_fill),
        .m_axis_tvalid(d_tvalid), .m_axis_tready(d_rdy), .m_axis_tdata(d_tdata),
        .m_axis_tlast(d_tlast), .m_axis_tuser(d_tuser), .frame_done(d_done), .frame_cnt(d_fcnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic [1:0]  ps;
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        u;
        logic        dn;
        logic [15:0] fc;
    } row_t;

    row_t tab[36];

    function automatic row_t mk(input logic en, input logic rdy, input logic [1:0] ps,
                                input logic v, input logic [7:0] d, input logic l,
                                input logic u, input logic dn, input logic [15:0] fc);
        row_t r;
        r.en = en; r.rdy = rdy; r.ps = ps; r.v = v; r.d = d;
        r.l = l; r.u = u; r.dn = dn; r.fc = fc;
        return r;
    endfunction

    initial begin
        int seen_last;
        int found;
        int nb;
        int bx;
        int by;
        int ndone;
        logic [7:0] ev;

        // Frame 1 with tready held high; row = expected outputs now, inputs for the next edge
        tab[0]  = mk(1,1,0, 0,8'd0,0,0,0,16'd0);
        tab[1]  = mk(0,1,0, 1,8'd0,0,1,0,16'd0);
        tab[2]  = mk(0,1,0, 1,8'd1,0,0,0,16'd0);
        tab[3]  = mk(0,1,0, 1,8'd2,0,0,0,16'd0);
        tab[4]  = mk(0,1,0, 1,8'd3,1,0,0,16'd0);
        tab[5]  = mk(0,1,0, 0,8'd0,0,0,0,16'd0);
        tab[6]  = mk(0,1,0, 0,8'd0,0,0,0,16'd0);
        tab[7]  = mk(0,1,0, 1,8'd0,0,0,0,16'd0);
        tab[8]  = mk(0,1,0, 1,8'd1,0,0,0,16'd0);
        tab[9]  = mk(0,1,0, 1,8'd2,0,0,0,16'd0);
        tab[10] = mk(0,1,0, 1,8'd3,1,0,0,16'd0);
        tab[11] = mk(0,1,0, 0,8'd0,0,0,1,16'd1);
        tab[12] = mk(0,1,0, 0,8'd0,0,0,0,16'd1);
        tab[13] = mk(0,1,0, 0,8'd0,0,0,0,16'd1);
        tab[14] = mk(1,1,0, 0,8'd0,0,0,0,16'd1);
        // Frame 2 with tready 1,0,0,1 and a pattern change mid-frame
        tab[15] = mk(0,1,0, 1,8'd0,0,1,0,16'd1);
        tab[16] = mk(0,0,0, 1,8'd1,0,0,0,16'd1);
        tab[17] = mk(0,0,0, 1,8'd1,0,0,0,16'd1);
        tab[18] = mk(0,1,0, 1,8'd1,0,0,0,16'd1);
        tab[19] = mk(0,1,0, 1,8'd2,0,0,0,16'd1);
        tab[20] = mk(0,0,3, 1,8'd3,1,0,0,16'd1);
        tab[21] = mk(0,0,3, 1,8'd3,1,0,0,16'd1);
        tab[22] = mk(0,1,3, 1,8'd3,1,0,0,16'd1);
        tab[23] = mk(0,1,3, 0,8'd0,0,0,0,16'd1);
        tab[24] = mk(0,0,3, 0,8'd0,0,0,0,16'd1);
        tab[25] = mk(0,0,3, 1,8'd0,0,0,0,16'd1);
        tab[26] = mk(0,1,3, 1,8'd0,0,0,0,16'd1);
        tab[27] = mk(0,1,3, 1,8'd1,0,0,0,16'd1);
        tab[28] = mk(0,0,3, 1,8'd2,0,0,0,16'd1);
        tab[29] = mk(0,0,3, 1,8'd2,0,0,0,16'd1);
        tab[30] = mk(0,1,3, 1,8'd2,0,0,0,16'd1);
        tab[31] = mk(0,1,3, 1,8'd3,1,0,0,16'd1);
        tab[32] = mk(0,0,3, 0,8'd0,0,0,1,16'd2);
        tab[33] = mk(0,0,3, 0,8'd0,0,0,0,16'd2);
        tab[34] = mk(0,1,3, 0,8'd0,0,0,0,16'd2);
        tab[35] = mk(0,1,3, 0,8'd0,0,0,0,16'd2);

        repeat (3) @(negedge aclk);
        chk("rst_tvalid", {31'd0, a_tvalid}, 0);
        chk("rst_tdata",  {24'd0, a_tdata}, 0);
        chk("rst_tlast",  {31'd0, a_tlast}, 0);
        chk("rst_tuser",  {31'd0, a_tuser}, 0);
        chk("rst_done",   {31'd0, a_done}, 0);
        chk("rst_fcnt",   {16'd0, a_fcnt}, 0);
        aresetn = 1'b1;

        for (int i = 0; i < 36; i++) begin
            @(negedge aclk);
            chk($sformatf("tab%0d_tvalid", i), {31'd0, a_tvalid}, {31'd0, tab[i].v});
            if (tab[i].v) chk($sformatf("tab%0d_tdata", i), {24'd0, a_tdata}, {24'd0, tab[i].d});
            chk($sformatf("tab%0d_tlast", i), {31'd0, a_tlast}, {31'd0, tab[i].l});
            chk($sformatf("tab%0d_tuser", i), {31'd0, a_tuser}, {31'd0, tab[i].u});
            chk($sformatf("tab%0d_done", i),  {31'd0, a_done},  {31'd0, tab[i].dn});
            chk($sformatf("tab%0d_fcnt", i),  {16'd0, a_fcnt},  {16'd0, tab[i].fc});
            a_en  = tab[i].en;
            a_rdy = tab[i].rdy;
            a_ps  = tab[i].ps;
        end

        // Asynchronous reset during line 1, beat 2
        a_ps = 0; a_rdy = 1; a_en = 1;
        seen_last = 0; found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            a_en = 0;
            if (a_tvalid && seen_last != 0 && a_tdata == 8'd2) begin
                found = 1;
                break;
            end
            if (a_tvalid && a_tlast) seen_last = 1;
        end
        chk("arst_reach", found, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_tvalid", {31'd0, a_tvalid}, 0);
        chk("arst_tdata",  {24'd0, a_tdata}, 0);
        chk("arst_tlast",  {31'd0, a_tlast}, 0);
        chk("arst_tuser",  {31'd0, a_tuser}, 0);
        chk("arst_done",   {31'd0, a_done}, 0);
        chk("arst_fcnt",   {16'd0, a_fcnt}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        a_en = 1;
        @(negedge aclk);
        a_en = 0;
        chk("arst_first_tvalid", {31'd0, a_tvalid}, 1);
        chk("arst_first_tuser",  {31'd0, a_tuser}, 1);
        chk("arst_first_tdata",  {24'd0, a_tdata}, 0);
        chk("arst_first_tlast",  {31'd0, a_tlast}, 0);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (a_done) begin
                found = 1;
                break;
            end
        end
        chk("arst_frame_done", found, 1);
        chk("arst_frame_cnt", {16'd0, a_fcnt}, 1);

        // Zero blanking, enable held then dropped mid-frame
        b_rdy = 1; b_en = 1;
        for (int k = 0; k < 24; k++) begin
            @(negedge aclk);
            chk($sformatf("nb%0d_tvalid", k), {31'd0, b_tvalid}, 1);
            chk($sformatf("nb%0d_tdata", k),  {24'd0, b_tdata}, k % 4);
            chk($sformatf("nb%0d_tlast", k),  {31'd0, b_tlast}, (k % 4 == 3) ? 1 : 0);
            chk($sformatf("nb%0d_tuser", k),  {31'd0, b_tuser}, (k % 8 == 0) ? 1 : 0);
            chk($sformatf("nb%0d_done", k),   {31'd0, b_done}, (k % 8 == 0 && k > 0) ? 1 : 0);
            if (k == 19) b_en = 0;
        end
        @(negedge aclk);
        chk("nb_end_tvalid", {31'd0, b_tvalid}, 0);
        chk("nb_end_fcnt",   {16'd0, b_fcnt}, 3);

        // Checker pattern, pattern_sel changed after the first line
        c_rdy = 1; c_en = 1;
        nb = 0; bx = 0; by = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge aclk);
            c_en = 0;
            if (c_tvalid) begin
                ev = (((bx ^ by) & 8) != 0) ? 8'hFF : 8'h00;
                chk($sformatf("ckr_x%0d_y%0d_tdata", bx, by), {24'd0, c_tdata}, {24'd0, ev});
                chk($sformatf("ckr_x%0d_y%0d_tlast", bx, by), {31'd0, c_tlast}, (bx == 15) ? 1 : 0);
                chk($sformatf("ckr_x%0d_y%0d_tuser", bx, by), {31'd0, c_tuser}, (bx == 0 && by == 0) ? 1 : 0);
                nb++;
                if (bx == 15) begin
                    bx = 0;
                    by++;
                end else begin
                    bx++;
                end
                if (nb == 16) c_ps = 3;
                if (nb == 256) break;
            end
        end
        chk("ckr_beats", nb, 256);
        @(negedge aclk);
        chk("ckr_done", {31'd0, c_done}, 1);
        chk("ckr_fcnt", {16'd0, c_fcnt}, 1);

        // Frame counter wrap on a 1x1 image
        d_rdy = 1; d_en = 1;
        ndone = 0; found = 0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge aclk);
            if (d_done) ndone++;
            if (d_fcnt == 16'hFFFF) begin
                found = 1;
                break;
            end
        end
        chk("wrap_reach", found, 1);
        chk("wrap_pulses", ndone, 65535);
        chk("wrap_tuser", {31'd0, d_tuser}, 1);
        chk("wrap_tlast", {31'd0, d_tlast}, 1);
        chk("wrap_tdata", {24'd0, d_tdata}, 0);
        d_en = 0;
        @(negedge aclk);
        chk("wrap_fcnt_zero", {16'd0, d_fcnt}, 0);
        chk("wrap_last_done", {31'd0, d_done}, 1);
        chk("wrap_idle", {31'd0, d_tvalid}, 0);
        @(negedge aclk);
        chk("wrap_done_single", {31'd0, d_done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_img_source.md
AXIS_IMG_SOURCE -- requirements
Module: axis_img_source

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 640, SHALL set the number of pixels per line.
REQ-003 Parameter IMG_HEIGHT, default 480, SHALL set the number of lines per frame.
REQ-004 Parameter HBLANK, default 16, SHALL set the idle cycles after each line (0 allowed).
REQ-005 Parameter VBLANK, default 64, SHALL set the idle cycles after each frame (0 allowed).
REQ-006 Port aclk, input, 1 bit: single clock; all logic SHALL be rising-edge.
REQ-007 Port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port enable, input, 1 bit: run request, sampled only in IDLE and at frame end.
REQ-009 Port pattern_sel, input, 2 bits: 0 h-ramp, 1 v-ramp, 2 checker, 3 constant.
REQ-010 Port fill_value, input, DATA_WIDTH bits: pixel value for the constant pattern.
REQ-011 Port m_axis_tvalid, output, 1 bit: beat valid.
REQ-012 Port m_axis_tready, input, 1 bit: sink ready.
REQ-013 Port m_axis_tdata, output, DATA_WIDTH bits: pixel.
REQ-014 Port m_axis_tlast, output, 1 bit: last pixel of a line.
REQ-015 Port m_axis_tuser, output, 1 bit: first pixel of a frame (SOF).
REQ-016 Port frame_done, output, 1 bit: one-cycle pulse after the last beat of a frame.
REQ-017 Port frame_cnt, output, 16 bits: completed-frame count.

Function
REQ-018 The FSM SHALL have states IDLE, LINE, HBLANK and VBLANK.
REQ-019 In IDLE with enable=1, the block SHALL latch pattern_sel and fill_value, set x=0 and y=0, and assert m_axis_tvalid on the next cycle (1-cycle latency).
REQ-020 All m_axis_* outputs SHALL be registered.
REQ-021 While m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast and tuser SHALL hold stable.
REQ-022 A beat SHALL transfer only when tvalid=1 and tready=1; x SHALL advance only on a transfer.
REQ-023 m_axis_tvalid SHALL stay high in LINE regardless of tready and SHALL be 0 in IDLE, HBLANK and VBLANK.
REQ-024 m_axis_tuser SHALL be 1 only on the beat with x=0 and y=0.
REQ-025 m_axis_tlast SHALL be 1 only on the beat with x=IMG_WIDTH-1.
REQ-026 Pixel values by pattern:
- h-ramp: x[DATA_WIDTH-1:0], wrapping.
- v-ramp: y[DATA_WIDTH-1:0], wrapping.
- checker: all ones when x[3]^y[3]=1, else 0.
- constant: latched fill_value.
REQ-027 On a tlast transfer with y<IMG_HEIGHT-1, the block SHALL increment y, clear x, and then:
- enter HBLANK for exactly HBLANK cycles, then return to LINE; or
- if HBLANK=0, go straight to LINE with no idle cycle.
REQ-028 On the tlast transfer with y=IMG_HEIGHT-1, the block SHALL:
- pulse frame_done for one cycle on the next clock;
- increment frame_cnt modulo 2^16;
- enter VBLANK for VBLANK cycles (skipped if 0).
REQ-029 At VBLANK end, enable=1 SHALL start a new frame (re-latching pattern_sel and fill_value, as in REQ-019); enable=0 SHALL return to IDLE.
REQ-030 Deasserting enable mid-frame SHALL NOT truncate the frame; the current frame SHALL complete.
REQ-031 pattern_sel and fill_value changes mid-frame SHALL have no effect until the next frame start.

Reset
REQ-032 While aresetn=0, the block SHALL hold the FSM in IDLE, x=0, y=0, tvalid=0, tdata=0, tlast=0, tuser=0, frame_done=0 and frame_cnt=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately; after release, the next frame SHALL start with tuser=1 at x=0, y=0.

Verification
REQ-034 IMG_WIDTH=4, IMG_HEIGHT=2, HBLANK=2, VBLANK=3, tready=1, h-ramp, enable pulsed once:
- required beats 0,1,2,3 (tuser on beat 0, tlast on beat 3), then 2 idle cycles;
- then beats 0,1,2,3 (tlast on beat 3);
- then frame_done=1 for one cycle, frame_cnt=1, then IDLE.
REQ-035 Same config, tready toggled 1,0,0,1 per cycle: no beat lost or duplicated; tdata stable while stalled; sequence identical to REQ-034.
REQ-036 HBLANK=0, VBLANK=0, enable held 1: tvalid stays continuously high across line and frame boundaries; tuser recurs every IMG_WIDTH*IMG_HEIGHT beats.
REQ-037 Checker, IMG_WIDTH=16, IMG_HEIGHT=16:
- line 0: beats 0-7 = 0x00, beats 8-15 = 0xFF;
- line 8: beats 0-7 = 0xFF, beats 8-15 = 0x00.
REQ-038 aresetn pulsed low during line 1, beat 2: all outputs go to 0 asynchronously; with enable=1 after release, the first beat has tuser=1 and tdata=0.
REQ-039 frame_cnt forced through 65535 completed frames, then one more frame: frame_cnt wraps to 0 and frame_done still pulses once.
